psl_job_control: RTL and testbench

PSL-side job-control sequencer for the CAPI simulation and bring-up environment. It drives the host-to-AFU control interface (`ha_jval`, `ha_jcom`, `ha_jea` plus odd parity) and watches the AFU's `ah_jrunning`, `ah_jdone` and `ah_jerror` responses. A test harness or host model issues a simple request, and the block sequences a full job: reset command, wait for done, start command with the WED, wait for running, wait for completion. It reports completion or timeout back to the requester.

---
 rtl/psl_job_control.sv | 147 ++++++++++++++
 tb/tb_psl_job_control.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psl_job_control.sv
// psl_job_control: PSL-side job-control sequencer.
// Issues reset/start job commands to the AFU, waits for its done/running
// responses with a bounded timeout, and reports completion or timeout.
module psl_job_control #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        ha_pclock,
    input  logic        reset,
    input  logic        req_start,
    input  logic        req_reset,
    input  logic [63:0] req_wed,
    output logic        ha_jval,
    output logic [7:0]  ha_jcom,
    output logic        ha_jcompar,
    output logic [63:0] ha_jea,
    output logic        ha_jeapar,
    input  logic        ah_jrunning,
    input  logic        ah_jdone,
    input  logic [63:0] ah_jerror,
    output logic        busy,
    output logic        job_running,
    output logic        job_complete,
    output logic [63:0] job_error,
    output logic        timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [7:0] JCOM_RESET = 8'h80;
    localparam logic [7:0] JCOM_START = 8'h90;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_CMD,
        S_RST_WAIT,
        S_START_CMD,
        S_START_WAIT,
        S_RUNNING,
        S_DONE,
        S_TMO
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  tmo_cnt;
    logic           start_pending;
    logic [63:0]    wed_q;
    logic           expired;
    logic           cmd_val;
    logic [7:0]     cmd_com;
    logic [63:0]    cmd_ea;

    assign expired = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Next-state selection; responses from the AFU take priority over expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (req_start || req_reset) state_nxt = S_RST_CMD;
            S_RST_CMD:    state_nxt = S_RST_WAIT;
            S_RST_WAIT: begin
                if (ah_jdone)     state_nxt = start_pending ? S_START_CMD : S_DONE;
                else if (expired) state_nxt = S_TMO;
            end
            S_START_CMD:  state_nxt = S_START_WAIT;
            S_START_WAIT: begin
                if (ah_jdone)         state_nxt = S_DONE;
                else if (ah_jrunning) state_nxt = S_RUNNING;
                else if (expired)     state_nxt = S_TMO;
            end
            S_RUNNING: begin
                if (ah_jdone)       state_nxt = S_DONE;
                else if (req_reset) state_nxt = S_RST_CMD;
            end
            S_DONE:       state_nxt = S_IDLE;
            S_TMO:        state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Command bus contents for the next cycle.
    // The reset command appears together with RST_CMD; the start command is
    // loaded while in START_CMD (where the WED is staged) and so appears the
    // cycle after, i.e. in the first START_WAIT cycle.
    always_comb begin
        cmd_val = 1'b0;
        cmd_com = '0;
        cmd_ea  = '0;
        if (state_nxt == S_RST_CMD) begin
            cmd_val = 1'b1;
            cmd_com = JCOM_RESET;
        end else if (state == S_START_CMD) begin
            cmd_val = 1'b1;
            cmd_com = JCOM_START;
            cmd_ea  = wed_q;
        end
    end

    // State, wait counter, request latches and registered outputs.
    always_ff @(posedge ha_pclock) begin
        if (reset) begin
            state         <= S_IDLE;
            tmo_cnt       <= '0;
            start_pending <= 1'b0;
            wed_q         <= '0;
            ha_jval       <= 1'b0;
            ha_jcom       <= '0;
            ha_jcompar    <= 1'b1;
            ha_jea        <= '0;
            ha_jeapar     <= 1'b1;
            busy          <= 1'b0;
            job_running   <= 1'b0;
            job_complete  <= 1'b0;
            job_error     <= '0;
            timeout       <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == S_RST_CMD || state == S_START_CMD)
                tmo_cnt <= '0;
            else if (state == S_RST_WAIT || state == S_START_WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (state == S_IDLE && (req_start || req_reset)) begin
                start_pending <= req_start;
                if (req_start)
                    wed_q <= req_wed;
                job_error <= '0;
            end else if (state == S_RUNNING && state_nxt == S_RST_CMD) begin
                start_pending <= 1'b0;
            end

            if (state_nxt == S_DONE)
                job_error <= ah_jerror;

            ha_jval      <= cmd_val;
            ha_jcom      <= cmd_com;
            ha_jcompar   <= ~^cmd_com;
            ha_jea       <= cmd_ea;
            ha_jeapar    <= ~^cmd_ea;
            busy         <= (state_nxt != S_IDLE);
            job_running  <= (state_nxt == S_RUNNING);
            job_complete <= (state_nxt == S_DONE);
            timeout      <= (state_nxt == S_TMO);
        end
    end

endmodule

// File: tb/tb_psl_job_control.sv
// tb_psl_job_control: directed and randomized checks of psl_job_control
// against a deadline-based job model.
module tb_psl_job_control;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_start = 1'b0;
    logic        req_reset = 1'b0;
    logic [63:0] req_wed = '0;
    logic        ha_jval;
    logic [7:0]  ha_jcom;
    logic        ha_jcompar;
    logic [63:0] ha_jea;
    logic        ha_jeapar;
    logic        ah_jrunning = 1'b0;
    logic        ah_jdone = 1'b0;
    logic [63:0] ah_jerror = '0;
    logic        busy;
    logic        job_running;
    logic        job_complete;
    logic [63:0] job_error;
    logic        timeout;

    always #5 clk = ~clk;

    psl_job_control #(.TIMEOUT_CYCLES(T)) dut (
        .ha_pclock    (clk),
        .reset        (reset),
        .req_start    (req_start),
        .req_reset    (req_reset),
        .req_wed      (req_wed),
        .ha_jval      (ha_jval),
        .ha_jcom      (ha_jcom),
        .ha_jcompar   (ha_jcompar),
        .ha_jea       (ha_jea),
        .ha_jeapar    (ha_jeapar),
        .ah_jrunning  (ah_jrunning),
        .ah_jdone     (ah_jdone),
        .ah_jerror    (ah_jerror),
        .busy         (busy),
        .job_running  (job_running),
        .job_complete (job_complete),
        .job_error    (job_error),
        .timeout      (timeout)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Job phases; waits are bounded by an absolute deadline cycle number.
    localparam int P_IDLE = 0, P_RCMD = 1, P_RWAIT = 2, P_SCMD = 3,
                   P_SWAIT = 4, P_RUN = 5, P_DONE = 6, P_TMO = 7;

    int          m_ph = P_IDLE;
    bit          m_pend = 0;
    logic [63:0] m_wed = '0;
    logic [63:0] m_err = '0;
    longint      cyc = 0;
    longint      deadline = 0;
    bit          model_live = 0;

    logic        e_jval, e_busy, e_run, e_cmp, e_tmo;
    logic [7:0]  e_jcom;
    logic [63:0] e_jea;

    always @(posedge clk) begin : model
        bit issue;
        issue = 0;
        if (reset) begin
            m_ph = P_IDLE; m_pend = 0; m_wed = '0; m_err = '0;
        end else begin
            case (m_ph)
                P_IDLE: if (req_start || req_reset) begin
                    m_ph = P_RCMD; m_pend = req_start; m_err = '0;
                    if (req_start) m_wed = req_wed;
                end
                P_RCMD: begin m_ph = P_RWAIT; deadline = cyc + T; end
                P_RWAIT: begin
                    if (ah_jdone) begin
                        if (m_pend) m_ph = P_SCMD;
                        else begin m_ph = P_DONE; m_err = ah_jerror; end
                    end else if (cyc == deadline) m_ph = P_TMO;
                end
                P_SCMD: begin m_ph = P_SWAIT; deadline = cyc + T; issue = 1; end
                P_SWAIT: begin
                    if (ah_jdone) begin m_ph = P_DONE; m_err = ah_jerror; end
                    else if (ah_jrunning) m_ph = P_RUN;
                    else if (cyc == deadline) m_ph = P_TMO;
                end
                P_RUN: begin
                    if (ah_jdone) begin m_ph = P_DONE; m_err = ah_jerror; end
                    else if (req_reset) begin m_ph = P_RCMD; m_pend = 0; end
                end
                default: m_ph = P_IDLE;
            endcase
        end
        cyc++;
        e_jval = (m_ph == P_RCMD) || issue;
        e_jcom = (m_ph == P_RCMD) ? 8'h80 : (issue ? 8'h90 : 8'h00);
        e_jea  = issue ? m_wed : 64'h0;
        e_busy = (m_ph != P_IDLE);
        e_run  = (m_ph == P_RUN);
        e_cmp  = (m_ph == P_DONE);
        e_tmo  = (m_ph == P_TMO);
        model_live = 1;
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("m_jval",    ha_jval,      e_jval);
            chk("m_jcom",    ha_jcom,      e_jcom);
            chk("m_jcompar", ha_jcompar,   ($countones(e_jcom) % 2) == 0);
            chk("m_jea",     ha_jea,       e_jea);
            chk("m_jeapar",  ha_jeapar,    ($countones(e_jea) % 2) == 0);
            chk("m_busy",    busy,         e_busy);
            chk("m_running", job_running,  e_run);
            chk("m_complete", job_complete, e_cmp);
            chk("m_error",   job_error,    m_err);
            chk("m_timeout", timeout,      e_tmo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit saw;

        // Reset state.
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_jval", ha_jval, 0);
        chk("rst_jcompar", ha_jcompar, 1);
        chk("rst_jeapar", ha_jeapar, 1);
        reset = 0;
        tick();

        // Full job.
        req_start = 1; req_wed = 64'h0000_0000_1234_5000;
        tick();
        req_start = 0; req_wed = '0;
        chk("full_rcmd_val", ha_jval, 1);
        chk("full_rcmd_com", ha_jcom, 8'h80);
        chk("full_rcmd_par", ha_jcompar, 0);
        tick();
        chk("full_jval_single", ha_jval, 0);
        tick();
        ah_jdone = 1;
        tick();
        ah_jdone = 0;
        chk("full_scmd_stage", ha_jval, 0);
        tick();
        chk("full_scmd_val", ha_jval, 1);
        chk("full_scmd_com", ha_jcom, 8'h90);
        chk("full_scmd_par", ha_jcompar, 1);
        chk("full_scmd_jea", ha_jea, 64'h0000_0000_1234_5000);
        chk("full_scmd_eapar", ha_jeapar, 0);
        tick();
        ah_jrunning = 1;
        tick();
        chk("full_running", job_running, 1);
        req_start = 1;
        tick();
        req_start = 0;
        chk("busy_start_ignored", ha_jval, 0);
        repeat (17) tick();
        ah_jdone = 1; ah_jerror = '0;
        tick();
        ah_jdone = 0; ah_jrunning = 0;
        chk("full_complete", job_complete, 1);
        chk("full_error", job_error, 0);
        tick();
        chk("full_complete_pulse", job_complete, 0);
        chk("full_idle", busy, 0);

        // Reset only, done 5 cycles after the request.
        req_reset = 1;
        tick();
        req_reset = 0;
        chk("ronly_cmd", ha_jcom, 8'h80);
        repeat (4) tick();
        ah_jdone = 1; ah_jerror = 64'hDEAD_BEEF_0000_0001;
        tick();
        ah_jdone = 0; ah_jerror = '0;
        chk("ronly_complete", job_complete, 1);
        chk("ronly_error", job_error, 64'hDEAD_BEEF_0000_0001);
        repeat (3) tick();
        chk("ronly_error_held", job_error, 64'hDEAD_BEEF_0000_0001);

        // Reset timeout: timeout 8 cycles after entering RST_WAIT.
        req_start = 1; req_wed = 64'hFFFF_0000_0000_0042;
        tick();
        req_start = 0;
        chk("tmo_cmd", ha_jcom, 8'h80);
        chk("tmo_error_cleared", job_error, 0);
        n = 0; saw = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            tick();
            if (ha_jval) saw = 1;
            if (timeout) n = i;
        end
        chk("tmo_cycles", n, T + 1);
        chk("tmo_no_cmd", saw, 0);
        tick();
        chk("tmo_idle", busy, 0);

        // Abort from RUNNING.
        req_start = 1; req_wed = 64'h77;
        tick();
        req_start = 0;
        tick();
        ah_jdone = 1;
        tick();
        ah_jdone = 0;
        tick();
        chk("abort_start", ha_jcom, 8'h90);
        ah_jrunning = 1;
        repeat (2) tick();
        chk("abort_running", job_running, 1);
        req_reset = 1;
        tick();
        req_reset = 0;
        chk("abort_cmd_val", ha_jval, 1);
        chk("abort_cmd_com", ha_jcom, 8'h80);
        ah_jrunning = 0;
        repeat (2) tick();
        ah_jdone = 1; ah_jerror = 64'h5;
        tick();
        ah_jdone = 0; ah_jerror = '0;
        chk("abort_complete", job_complete, 1);
        chk("abort_not_running", job_running, 0);
        chk("abort_error", job_error, 64'h5);
        tick();

        // Simultaneous start and reset: start wins; done+running together ends in DONE.
        req_start = 1; req_reset = 1; req_wed = 64'hA5;
        tick();
        req_start = 0; req_reset = 0; req_wed = '0;
        tick();
        ah_jdone = 1;
        tick();
        ah_jdone = 0;
        tick();
        chk("coll_start_com", ha_jcom, 8'h90);
        chk("coll_start_jea", ha_jea, 64'hA5);
        tick();
        ah_jdone = 1; ah_jrunning = 1; ah_jerror = 64'h7;
        tick();
        ah_jdone = 0; ah_jrunning = 0; ah_jerror = '0;
        chk("coll_both_complete", job_complete, 1);
        chk("coll_both_notrun", job_running, 0);
        tick();

        // Done on the final timeout cycle.
        req_reset = 1;
        tick();
        req_reset = 0;
        repeat (T) tick();
        ah_jdone = 1;
        tick();
        ah_jdone = 0;
        chk("edge_complete", job_complete, 1);
        chk("edge_no_timeout", timeout, 0);
        tick();

        // Reset during START_CMD.
        req_start = 1; req_wed = 64'h1;
        tick();
        req_start = 0;
        tick();
        ah_jdone = 1;
        tick();
        ah_jdone = 0;
        chk("mid_in_scmd", ha_jval, 0);
        reset = 1;
        tick();
        chk("mid_jval", ha_jval, 0);
        chk("mid_jcom", ha_jcom, 0);
        chk("mid_jcompar", ha_jcompar, 1);
        chk("mid_busy", busy, 0);
        chk("mid_complete", job_complete, 0);
        reset = 0;
        tick();

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 399) == 0);
            req_start   = ($urandom_range(0, 11) == 0);
            req_reset   = ($urandom_range(0, 15) == 0);
            req_wed     = {$urandom, $urandom};
            ah_jdone    = ($urandom_range(0, 6) == 0);
            ah_jrunning = ($urandom_range(0, 3) == 0);
            ah_jerror   = {$urandom, $urandom};
            tick();
        end
        reset = 1; req_start = 0; req_reset = 0; ah_jdone = 0; ah_jrunning = 0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
